// File: rtl/shim_abs_current_monitor.sv
// Sliding-window per-channel average monitor with sticky over-threshold flags.
// Optional SHIM_MON_PEAK_EN tracks the peak channel average; otherwise peak_avg is tied to 0.
module shim_abs_current_monitor #(
    parameter logic [15:0] SAMPLE_DIV  = 16'd1000,
    parameter int          LOG2_WINDOW = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         clear_flags,
    input  logic [119:0] abs_dac_val_concat,
    input  logic [14:0]  thresh_avg,
    output logic         window_full,
    output logic         over_thresh,
    output logic [7:0]   over_mask,
    output logic [14:0]  peak_avg,
    output logic         busy
);
    localparam int SW = 15 + LOG2_WINDOW;
    localparam int AW = 3 + LOG2_WINDOW;
    localparam logic [3:0] LAST_PHASE = 4'd10;

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
    state_t state_q, state_d;

    logic [15:0]            cnt_q, cnt_d;
    logic [3:0]             phase_q, phase_d;
    logic [LOG2_WINDOW-1:0] wr_ptr_q, wr_ptr_d;
    logic [119:0]           hold_q, hold_d;
    logic [SW-1:0]          sum_q [8];
    logic [SW-1:0]          sum_d [8];
    logic [14:0]            mem_q [2**AW];
    logic [14:0]            rd_q;
    logic [7:0]             over_mask_q, over_mask_d;
    logic                   over_thresh_q, over_thresh_d;

    logic          active, tick, upd_en, cmp_en;
    logic [2:0]    rd_ch, upd_ch, cmp_ch;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [14:0]   new_val, old_val, avg;
    logic [7:0]    viol;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = FILL;
                FILL:    if (phase_q == LAST_PHASE && wr_ptr_q == '0) state_d = RUN;
                RUN:     state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        window_full = (state_q == RUN);
        busy        = (phase_q != '0);
        over_mask   = over_mask_q;
        over_thresh = over_thresh_q;
    end

    // Phase p of the pipeline reads channel p-1, updates p-2, compares p-3 (3-bit wrap keeps it exact).
    always_comb begin
        active  = enable && (state_q != IDLE);
        tick    = active && (cnt_q == '0);
        rd_ch   = phase_q[2:0] - 3'd1;
        upd_ch  = phase_q[2:0] - 3'd2;
        cmp_ch  = phase_q[2:0] - 3'd3;
        upd_en  = active && (phase_q >= 4'd2) && (phase_q <= 4'd9);
        cmp_en  = active && (phase_q >= 4'd3) && (phase_q <= LAST_PHASE);
        rd_addr = {rd_ch, wr_ptr_q};
        wr_addr = {upd_ch, wr_ptr_q};
        new_val = hold_q[int'(upd_ch) * 15 +: 15];
        old_val = (state_q == FILL) ? '0 : rd_q;
        avg     = sum_q[cmp_ch][SW-1:LOG2_WINDOW];
    end

    always_comb begin
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        wr_ptr_d = wr_ptr_q;
        hold_d   = hold_q;
        for (int unsigned i = 0; i < 8; i++) sum_d[i] = sum_q[i];
        if (!active) begin
            cnt_d    = SAMPLE_DIV - 16'd1;
            phase_d  = '0;
            wr_ptr_d = '0;
            for (int unsigned i = 0; i < 8; i++) sum_d[i] = '0;
        end else begin
            if (phase_q == LAST_PHASE)  phase_d = '0;
            else if (phase_q != '0)     phase_d = phase_q + 4'd1;
            if (tick) begin
                cnt_d   = SAMPLE_DIV - 16'd1;
                hold_d  = abs_dac_val_concat;
                phase_d = 4'd1;
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
            if (upd_en) begin
                sum_d[upd_ch] = sum_q[upd_ch] + SW'(new_val) - SW'(old_val);
                if (upd_ch == 3'd7) wr_ptr_d = wr_ptr_q + LOG2_WINDOW'(1);
            end
        end
    end

    // A violation in the clearing cycle survives; other bits are dropped.
    always_comb begin
        viol = '0;
        if (cmp_en && (avg > thresh_avg)) viol[cmp_ch] = 1'b1;
        over_mask_d   = clear_flags ? viol : (over_mask_q | viol);
        over_thresh_d = clear_flags ? (|viol) : (over_thresh_q | (|viol));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= SAMPLE_DIV - 16'd1;
            phase_q       <= '0;
            wr_ptr_q      <= '0;
            hold_q        <= '0;
            over_mask_q   <= '0;
            over_thresh_q <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) sum_q[i] <= '0;
        end else begin
            cnt_q         <= cnt_d;
            phase_q       <= phase_d;
            wr_ptr_q      <= wr_ptr_d;
            hold_q        <= hold_d;
            over_mask_q   <= over_mask_d;
            over_thresh_q <= over_thresh_d;
            for (int unsigned i = 0; i < 8; i++) sum_q[i] <= sum_d[i];
        end
    end

    always_ff @(posedge clk) begin
        rd_q <= mem_q[rd_addr];
        if (upd_en) mem_q[wr_addr] <= new_val;
    end

`ifdef SHIM_MON_PEAK_EN
    logic [14:0] peak_q, peak_d;

    always_comb begin
        peak_d = clear_flags ? '0 : peak_q;
        if (cmp_en && (avg > peak_d)) peak_d = avg;
    end

    always_ff @(posedge clk) begin
        if (rst) peak_q <= '0;
        else     peak_q <= peak_d;
    end

    assign peak_avg = peak_q;
`else
    assign peak_avg = '0;
`endif

endmodule
